// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Purpose : Round-robin share of one external combinational ALU, one op in flight
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef ALU_DATA_WIDTH
`define ALU_DATA_WIDTH 32
`endif
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

module alu_arbiter #(
    parameter int DW = `ALU_DATA_WIDTH,
    parameter int CW = `ALU_CONTROL_WIDTH,
    parameter int AW = `INST_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_data_1,
    input  logic [DW-1:0] req0_data_2,
    input  logic [CW-1:0] req0_control,
    input  logic [AW-1:0] req0_pc,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_data_1,
    input  logic [DW-1:0] req1_data_2,
    input  logic [CW-1:0] req1_control,
    input  logic [AW-1:0] req1_pc,
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_zero,
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_zero,
    output logic [DW-1:0] alu_data_1,
    output logic [DW-1:0] alu_data_2,
    output logic [CW-1:0] alu_control,
    output logic [AW-1:0] alu_pc,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last_gnt;
    logic          gnt_id;
    logic          grant;
    logic          accept;
    logic          rsp_ready_sel;
    logic [DW-1:0] op1_q;
    logic [DW-1:0] op2_q;
    logic [CW-1:0] ctrl_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] res_q;
    logic          zero_q;

    // Under contention the requester that did not win last time is chosen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_gnt;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Gated by rst_n so ready is also low while reset is held.
    assign req0_ready    = rst_n && (state == IDLE) && req0_valid && !grant;
    assign req1_ready    = rst_n && (state == IDLE) && req1_valid && grant;
    assign accept        = req0_ready || req1_ready;
    assign rsp_ready_sel = gnt_id ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready_sel) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            ctrl_q   <= '0;
            pc_q     <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
        end else begin
            if (accept) begin
                last_gnt <= grant;
                gnt_id   <= grant;
                op1_q    <= grant ? req1_data_1  : req0_data_1;
                op2_q    <= grant ? req1_data_2  : req0_data_2;
                ctrl_q   <= grant ? req1_control : req0_control;
                pc_q     <= grant ? req1_pc      : req0_pc;
            end
            if (state == EXEC) begin
                res_q  <= alu_result;
                zero_q <= alu_zero;
            end
        end
    end

    assign alu_data_1  = op1_q;
    assign alu_data_2  = op2_q;
    assign alu_control = ctrl_q;
    assign alu_pc      = pc_q;

    assign rsp0_valid  = (state == RESP) && !gnt_id;
    assign rsp1_valid  = (state == RESP) && gnt_id;
    assign rsp0_data   = res_q;
    assign rsp1_data   = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Directed self-checking bench for alu_arbiter with a behavioural ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int AW = 32;

    localparam logic [CW-1:0] OP_ADD = 4'd0;
    localparam logic [CW-1:0] OP_SUB = 4'd1;
    localparam logic [CW-1:0] OP_OR  = 4'd2;
    localparam logic [CW-1:0] OP_JAL = 4'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_data_1, req0_data_2, req1_data_1, req1_data_2;
    logic [CW-1:0] req0_control, req1_control;
    logic [AW-1:0] req0_pc, req1_pc;
    logic          rsp0_valid, rsp0_ready, rsp0_zero;
    logic          rsp1_valid, rsp1_ready, rsp1_zero;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic [DW-1:0] alu_data_1, alu_data_2, alu_result;
    logic [CW-1:0] alu_control;
    logic [AW-1:0] alu_pc;
    logic          alu_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW), .CW(CW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data_1(req0_data_1), .req0_data_2(req0_data_2),
        .req0_control(req0_control), .req0_pc(req0_pc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data_1(req1_data_1), .req1_data_2(req1_data_2),
        .req1_control(req1_control), .req1_pc(req1_pc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .alu_data_1(alu_data_1), .alu_data_2(alu_data_2),
        .alu_control(alu_control), .alu_pc(alu_pc),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Behavioural stand-in for the external ALU.
    always_comb begin
        alu_result = '0;
        alu_zero   = 1'b0;
        case (alu_control)
            OP_ADD:  alu_result = alu_data_1 + alu_data_2;
            OP_SUB:  alu_result = alu_data_1 - alu_data_2;
            OP_OR:   alu_result = alu_data_1 | alu_data_2;
            OP_JAL:  alu_result = alu_pc + 32'd4;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_control == OP_JAL) ? 1'b1 : (alu_result == '0);
    end

    // A pending request may not be withdrawn before it is accepted.
    a_hold0: assert property (@(posedge clk) disable iff (!rst_n)
        (req0_valid && !req0_ready) |=> req0_valid)
        else begin n_fail++; $display("FAIL hold0: req0_valid withdrawn before acceptance"); end
    a_hold1: assert property (@(posedge clk) disable iff (!rst_n)
        (req1_valid && !req1_ready) |=> req1_valid)
        else begin n_fail++; $display("FAIL hold1: req1_valid withdrawn before acceptance"); end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req0(input logic v, input logic [CW-1:0] op, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_control = op; req0_data_1 = a; req0_data_2 = b; req0_pc = '0;
    endtask

    task automatic set_req1(input logic v, input logic [CW-1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc);
        req1_valid = v; req1_control = op; req1_data_1 = a; req1_data_2 = b; req1_pc = pc;
    endtask

    initial begin
        rst_n = 1'b0;
        set_req0(1'b0, OP_ADD, 0, 0);
        set_req1(1'b0, OP_ADD, 0, 0, 0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #3;
        check("reset_req0_ready", {31'd0, req0_ready}, 0);
        check("reset_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 0);
        check("reset_alu_data_1", alu_data_1, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("idle_no_ready", {30'd0, req1_ready, req0_ready}, 0);

        // Single ADD on requester 0.
        set_req0(1'b1, OP_ADD, 5, 7);
        rsp0_ready = 1'b1;
        #1 check("single_ready0", {31'd0, req0_ready}, 1);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        check("single_exec_ready0", {31'd0, req0_ready}, 0);
        check("single_exec_alu_op", {alu_data_1[15:0], alu_data_2[15:0]}, {16'd5, 16'd7});
        check("single_exec_rsp0_valid", {31'd0, rsp0_valid}, 0);
        tick();
        check("single_rsp0_valid", {31'd0, rsp0_valid}, 1);
        check("single_rsp0_data", rsp0_data, 12);
        check("single_rsp0_zero", {31'd0, rsp0_zero}, 0);
        check("single_rsp1_valid", {31'd0, rsp1_valid}, 0);
        tick();
        check("single_done", {31'd0, rsp0_valid}, 0);

        // Contention from reset: req0 wins first, then req1.
        rst_n = 1'b0;
        set_req0(1'b1, OP_SUB, 9, 9);
        set_req1(1'b1, OP_OR, 32'hF0, 32'h0F, 0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1 check("cont1_grant", {30'd0, req1_ready, req0_ready}, 32'b01);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        check("cont1_exec_ready1", {31'd0, req1_ready}, 0);
        tick();
        check("cont1_rsp0", {rsp0_data[29:0], rsp0_zero, rsp0_valid}, {30'd0, 1'b1, 1'b1});
        tick();
        check("cont1_ready1", {31'd0, req1_ready}, 1);
        tick();
        set_req1(1'b0, OP_ADD, 0, 0, 0);
        tick();
        check("cont1_rsp1_valid", {31'd0, rsp1_valid}, 1);
        check("cont1_rsp1_data", rsp1_data, 32'hFF);
        check("cont1_rsp1_zero", {31'd0, rsp1_zero}, 0);
        tick();

        // Second simultaneous pair: req1 went last, so req0 first again.
        set_req0(1'b1, OP_ADD, 3, 4);
        set_req1(1'b1, OP_ADD, 10, 6, 0);
        #1 check("cont2_grant", {30'd0, req1_ready, req0_ready}, 32'b01);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        tick();
        check("cont2_rsp0_data", rsp0_data, 7);
        tick();
        check("cont2_ready1", {31'd0, req1_ready}, 1);
        tick();
        set_req1(1'b0, OP_ADD, 0, 0, 0);
        tick();
        check("cont2_rsp1_data", {rsp1_data[30:0], rsp1_valid}, {31'd16, 1'b1});
        tick();

        // req0 alone, then a pair: round-robin now favours req1.
        set_req0(1'b1, OP_ADD, 2, 3);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        tick(); tick();
        set_req0(1'b1, OP_ADD, 10, 20);
        set_req1(1'b1, OP_SUB, 50, 8, 0);
        rsp1_ready = 1'b0;
        #1 check("rr_grant_req1", {30'd0, req1_ready, req0_ready}, 32'b10);
        tick();
        set_req1(1'b0, OP_ADD, 0, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp1_valid", {31'd0, rsp1_valid}, 1);
            check("bp_rsp1_data", rsp1_data, 42);
            check("bp_alu_data_1", alu_data_1, 50);
            check("bp_ready0", {31'd0, req0_ready}, 0);
            if (i < 4) tick();
        end
        rsp1_ready = 1'b1;
        tick();
        rsp1_ready = 1'b0;
        check("bp_release_rsp1", {31'd0, rsp1_valid}, 0);
        check("bp_ready0_after", {31'd0, req0_ready}, 1);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        check("bp_exec_alu_data_1", alu_data_1, 10);
        tick();
        check("bp_rsp0_data", {rsp0_data[30:0], rsp0_valid}, {31'd30, 1'b1});
        tick();

        // JAL on requester 1.
        set_req1(1'b1, OP_JAL, 0, 0, 32'h100);
        rsp1_ready = 1'b1;
        #1 check("jal_ready1", {31'd0, req1_ready}, 1);
        tick();
        set_req1(1'b0, OP_ADD, 0, 0, 0);
        tick();
        check("jal_rsp1_data", rsp1_data, 32'h104);
        check("jal_rsp1_zero", {30'd0, rsp1_zero, rsp1_valid}, 32'b11);
        tick();

        // Reset while in EXEC drops the operation.
        set_req0(1'b1, OP_ADD, 100, 1);
        rsp0_ready = 1'b1;
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        check("rexec_alu_data_1_pre", alu_data_1, 100);
        rst_n = 1'b0;
        #1 check("rexec_async_alu", alu_data_1, 0);
        check("rexec_async_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rexec_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 0);
        end
        set_req0(1'b1, OP_ADD, 1, 1);
        #1 check("rexec_ready0", {31'd0, req0_ready}, 1);
        tick();
        set_req0(1'b0, OP_ADD, 0, 0);
        tick();
        check("rexec_rsp0_data", {rsp0_data[30:0], rsp0_valid}, {31'd2, 1'b1});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
